id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Parametrised ID->EX pipeline stage register with valid/ready flow control, flush and bubble insertion.
//  Sits between decode and execute. Carries the control bundle, PC, operand data, register indices and immediate.
//  Bubbles and flushed slots always present all-zero control, so RegWrite/MemRead/MemWrite never fire on them.
//  A per-stage stall counter is provided for performance analysis.
// PARAMETERS
//  XLEN        32   width of pc, rs1_data, rs2_data, imm
//  RADDR_W     5    width of rs1/rs2/rd indices
//  CTRL_W      5    control bundle width; bit0 RegWrite, bit1 MemRead, bit2 MemWrite, bit3 MemToReg, bit4 ALUSrc, higher bits user-defined
//  STALL_CNT_W 16   width of the saturating stall counter
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        synchronous, active-high reset
//  flush         in   1        kill the stage contents (branch mispredict / trap)
//  in_valid      in   1        decode presents a valid instruction
//  in_ready      out  1        stage accepts the beat this cycle
//  ctrl_in       in   CTRL_W   control bundle from decode
//  pc_in         in   XLEN     instruction PC
//  rs1_data_in   in   XLEN     rs1 operand
//  rs2_data_in   in   XLEN     rs2 operand
//  rs1_in        in   RADDR_W  rs1 index
//  rs2_in        in   RADDR_W  rs2 index
//  rd_in         in   RADDR_W  rd index
//  imm_in        in   XLEN     sign-extended immediate
//  out_valid     out  1        EX holds a valid instruction
//  out_ready     in   1        EX consumes the beat this cycle
//  ctrl, pc, rs1_data, rs2_data, rs1, rs2, rd, imm   out   (widths as the inputs)   registered payload
//  stall_cnt     out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all outputs 0, including out_valid, payload, stall_cnt and any skid entry.
//    Reset overrides flush and any transfer in the same cycle.
//  - Transfer: accept when in_valid & in_ready; consume when out_valid & out_ready. Latency is 1 cycle from accept to out_valid.
//  - Hold: while out_valid & !out_ready, every output is stable. No payload bit may change.
//  - Bubble: output consumed (or empty) with no new accept -> out_valid<=0, ctrl<=0; the other payload fields hold their values.
//  - Invariant: out_valid==0 implies ctrl==0.
//  - Flush (clk edge with flush=1): out_valid<=0, ctrl<=0, skid entry invalidated.
//    A beat offered in the same cycle is accepted and discarded; in_ready is unaffected by flush.
//    Flush has priority over accept and hold.
//  - stall_cnt: +1 on each cycle with out_valid & !out_ready and no flush. Saturates at all-ones; it never wraps.
//    It is cleared only by reset.
// CONFIGURATION
//  Macro ID_EX_SKID_EN selects the input-side flow control.
//  - Without ID_EX_SKID_EN:
//    - in_ready = !out_valid | out_ready (combinational from out_ready).
//    - No extra storage.
//  - With ID_EX_SKID_EN:
//    - A one-entry skid buffer is added; in_ready = !skid_valid, a registered signal with no combinational path from out_ready.
//    - A beat accepted while the output is stalled goes to skid. When the output is consumed, skid moves to the output next cycle.
//    - Order is preserved; no beat is lost or duplicated.
//    - Throughput is 1 beat/cycle when out_ready=1.
// TESTING
//  1. Reset: drive reset=1 with in_valid=1, ctrl_in=5'h1F -> after the edge: out_valid=0, ctrl=0, pc=0, stall_cnt=0.
//  2. Streaming: out_ready=1; pc_in=0x100,0x104,0x108 on consecutive cycles -> the same PCs appear on pc 1 cycle later; out_valid=1 throughout.
//  3. Stall: hold pc=0x200 with out_ready=0 for 3 cycles -> pc/ctrl unchanged, stall_cnt=3.
//     Without the skid, in_ready=0. With ID_EX_SKID_EN, one more beat (pc 0x204) is accepted, then in_ready=0.
//  4. Flush during stall: out_valid=1, ctrl=5'h05, flush=1 -> next cycle out_valid=0, ctrl=0.
//     The skid is empty, and the beat offered during flush never appears on the output.
//  5. Bubble: in_valid=0, out_ready=1 after pc=0x300 -> out_valid=0, ctrl=0, pc stays 0x300.
//  6. Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=4'hF and stays at 4'hF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID->EX pipeline register with valid/ready flow control,
//               flush and bubble insertion, plus a saturating stall counter.
//
// Optional feature macro: ID_EX_SKID_EN
//   undefined : in_ready = !out_valid | out_ready, so in_ready depends
//               combinationally on out_ready.
//   defined   : adds a one-entry skid buffer. in_ready = !skid_valid comes
//               straight from a register, so there is no combinational path
//               from out_ready.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               kills the output slot and the skid entry
//   in_valid/in_ready   decode-side handshake
//   ctrl_in..imm_in     decode payload: ctrl bundle, pc, operands, indices, imm
//   out_valid/out_ready execute-side handshake
//   ctrl..imm           registered payload presented to execute
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter int CTRL_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [XLEN-1:0]        pc_in,
  input  logic [XLEN-1:0]        rs1_data_in,
  input  logic [XLEN-1:0]        rs2_data_in,
  input  logic [RADDR_W-1:0]     rs1_in,
  input  logic [RADDR_W-1:0]     rs2_in,
  input  logic [RADDR_W-1:0]     rd_in,
  input  logic [XLEN-1:0]        imm_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      ctrl,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  output logic [RADDR_W-1:0]     rs1,
  output logic [RADDR_W-1:0]     rs2,
  output logic [RADDR_W-1:0]     rd,
  output logic [XLEN-1:0]        imm,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    imm;
  } beat_t;

  beat_t                  in_beat;
  beat_t                  out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   accept, out_free;

  assign in_beat = '{ctrl: ctrl_in, pc: pc_in, rs1_data: rs1_data_in,
                     rs2_data: rs2_data_in, rs1: rs1_in, rs2: rs2_in,
                     rd: rd_in, imm: imm_in};

  // Output slot can take a new beat this cycle (empty or being consumed).
  assign out_free = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef ID_EX_SKID_EN
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Any beat accepted this cycle is dropped along with the skid entry.
      out_valid_d  = 1'b0;
      out_d.ctrl   = '0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready is low while skid is full, so accept and a skid drain
      // never happen together: order is preserved.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_d.ctrl  = '0;
      end
    end else if (accept) begin
      // Output stalled: park the beat.
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = out_free;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_d.ctrl  = '0;
    end else if (accept) begin
      out_d       = in_beat;
      out_valid_d = 1'b1;
    end else if (out_free) begin
      // Bubble: only ctrl is cleared, the rest of the payload holds.
      out_valid_d = 1'b0;
      out_d.ctrl  = '0;
    end
  end
`endif

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && !flush && !(&stall_q))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ctrl      = out_q.ctrl;
  assign pc        = out_q.pc;
  assign rs1_data  = out_q.rs1_data;
  assign rs2_data  = out_q.rs2_data;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign stall_cnt = stall_q;

endmodule
